// File: rtl/tone_gen_if.sv
// rtl/tone_gen_if.sv - frequency request and audio output bundle for tone_gen
interface tone_gen_if;
  logic [19:0] freq;
  logic        freq_valid;
  logic        load;
  logic        ready;
  logic        tone_out;
  logic        active;

  modport master (
    output freq, freq_valid, load,
    input  ready, tone_out, active
  );

  modport slave (
    input  freq, freq_valid, load,
    output ready, tone_out, active
  );
endinterface

// File: rtl/tone_gen.sv
// rtl/tone_gen.sv - square-wave tone generator, half-period from a multi-cycle restoring divider
// Optional TONE_GEN_GLITCHFREE_EN: a retuned half-period waits for the next toggle edge.
module tone_gen #(
  parameter int CLK_HZ = 50000000,
  parameter int DIV_W  = 32,
  parameter int CNT_W  = 24
) (
  input  logic      clk,
  input  logic      rst,
  tone_gen_if.slave bus
);
  localparam logic [1:0] S_SILENT = 2'd0;
  localparam logic [1:0] S_DIVIDE = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  // Remainder must hold any divisor 2*freq (21 bits) as well as the dividend width.
  localparam int RW = (DIV_W > 21) ? DIV_W : 21;
  localparam int QW = (DIV_W > CNT_W) ? DIV_W : CNT_W;
  localparam int IW = $clog2(DIV_W + 1);
  localparam logic [CNT_W-1:0] HALF_MAX = '1;

  logic [1:0]       state;
  logic             from_run;
  logic [DIV_W-1:0] dvd;
  logic [RW-1:0]    rem;
  logic [RW-1:0]    dsr;
  logic [RW:0]      sub;
  logic             qbit;
  logic [IW-1:0]    iter;
  logic [QW-1:0]    quo;
  logic [CNT_W-1:0] half_new;
  logic [CNT_W-1:0] half;
  logic [CNT_W-1:0] cnt;
  logic             tone;
  logic             running;
  logic             wrap;
  logic             silence;
`ifdef TONE_GEN_GLITCHFREE_EN
  logic [CNT_W-1:0] pend;
  logic             pend_v;
`endif

  // rem < dsr always holds, so the sign bit of the trial subtraction is the borrow.
  always_comb begin
    sub  = {rem, dvd[DIV_W-1]} - {1'b0, dsr};
    qbit = ~sub[RW];
    quo  = QW'({dvd[DIV_W-2:0], qbit});
    if (quo == '0)
      half_new = CNT_W'(1);
    else if (quo > QW'(HALF_MAX))
      half_new = HALF_MAX;
    else
      half_new = quo[CNT_W-1:0];
  end

  assign running = (state == S_RUN) || ((state == S_DIVIDE) && from_run);
  assign wrap    = (cnt == half - CNT_W'(1));
  assign silence = !bus.freq_valid || (bus.freq == '0);

  assign bus.ready    = (state != S_DIVIDE);
  assign bus.active   = running;
  assign bus.tone_out = tone;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_SILENT;
      from_run <= 1'b0;
      dvd      <= '0;
      rem      <= '0;
      dsr      <= '0;
      iter     <= '0;
      half     <= '0;
      cnt      <= '0;
      tone     <= 1'b0;
`ifdef TONE_GEN_GLITCHFREE_EN
      pend     <= '0;
      pend_v   <= 1'b0;
`endif
    end else begin
      if (running) begin
        if (wrap) begin
          cnt  <= '0;
          tone <= ~tone;
`ifdef TONE_GEN_GLITCHFREE_EN
          if (pend_v) begin
            half   <= pend;
            pend_v <= 1'b0;
          end
`endif
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end

      case (state)
        S_SILENT, S_RUN: begin
          if (bus.load) begin
            if (silence) begin
              state    <= S_SILENT;
              from_run <= 1'b0;
              tone     <= 1'b0;
              cnt      <= '0;
`ifdef TONE_GEN_GLITCHFREE_EN
              pend_v   <= 1'b0;
`endif
            end else begin
              state    <= S_DIVIDE;
              from_run <= (state == S_RUN);
              dvd      <= DIV_W'(CLK_HZ);
              rem      <= '0;
              dsr      <= RW'({bus.freq, 1'b0});
              iter     <= '0;
            end
          end
        end
        S_DIVIDE: begin
          dvd  <= {dvd[DIV_W-2:0], qbit};
          rem  <= qbit ? sub[RW-1:0] : {rem[RW-2:0], dvd[DIV_W-1]};
          iter <= iter + IW'(1);
          if (iter == IW'(DIV_W - 1)) begin
            state    <= S_RUN;
            from_run <= 1'b0;
            if (!from_run) begin
              half <= half_new;
              cnt  <= '0;
              tone <= 1'b0;
            end else begin
`ifdef TONE_GEN_GLITCHFREE_EN
              pend   <= half_new;
              pend_v <= 1'b1;
`else
              // Output level is kept; only the count restarts with the new period.
              half <= half_new;
              cnt  <= '0;
`endif
            end
          end
        end
        default: state <= S_SILENT;
      endcase
    end
  end
endmodule

// File: doc/tone_gen.md
# tone_gen

Square-wave tone generator fed by the note-to-frequency stage. Accepts an integer frequency in Hz with a valid flag, computes the half-period in clock cycles with a multi-cycle restoring divider, and toggles a 1-bit audio output at that rate until a new frequency or a silence command arrives. Drives the speaker/PWM pin directly.

## Interface
- CLK_HZ, 50000000, system clock frequency in Hz.
- DIV_W, 32, divider width; also number of divide iterations.
- CNT_W, 24, half-period counter width; quotient saturates to 2^CNT_W-1.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- freq  input  20  requested frequency in Hz (integer, upstream stage output).
- freq_valid  input  1  freq is a playable note; 0 means rest.
- load  input  1  one-cycle request to apply freq/freq_valid.
- ready  output  1  1 when a load will be accepted.
- tone_out  output  1  square-wave audio output.
- active  output  1  1 while a tone is being generated.

## Operation
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- States: SILENT, DIVIDE, RUN.
- Accept: load && ready at a rising edge. ready = 1 in SILENT and RUN, 0 in DIVIDE. load while ready=0 is ignored (not queued).
- Accepted with freq_valid=0 or freq==0: go SILENT immediately; tone_out=0, active=0, cnt=0.
- Accepted with valid nonzero freq: capture divisor = 2*freq (21 bits, zero-extended to DIV_W), dividend = CLK_HZ; enter DIVIDE.
- DIVIDE: restoring division, one quotient bit per cycle, MSB first, exactly DIV_W cycles. Result half = CLK_HZ / (2*freq), truncated.
- Clamp: half==0 → 1; half > 2^CNT_W-1 → 2^CNT_W-1.
- During DIVIDE from RUN: old tone keeps running with the old half-period. From SILENT: output stays 0.
- RUN: cnt counts 0..half-1; at cnt==half-1, cnt←0 and tone_out toggles. Output period = 2*half cycles, 50% duty.
- Entry to RUN from SILENT: cnt=0, tone_out=0, first rise after half cycles.
- active = 1 in RUN, and in DIVIDE when entered from RUN.

## Timing
- Reset values: state=SILENT, ready=1, tone_out=0, active=0, cnt=0, half=0.
- Load accepted at edge E: ready=0 from E+1 through E+DIV_W; half valid and state=RUN (or new value pending) at edge E+DIV_W; ready=1 from then.
- Silence load: tone_out=0, active=0 visible right after edge E.
- Simultaneous toggle and DIVIDE completion: toggle uses old half; new half applies per Configuration.
- Reset mid-DIVIDE or mid-RUN: abort, all outputs to reset values on that edge; partial quotient discarded.
- cnt compare uses current half; if new half < cnt (non-glitch-free mode only), cnt is reset, never wraps through 2^CNT_W.

## Configuration
- TONE_GEN_GLITCHFREE_EN defined: a new half computed while in RUN is held pending and loaded at the next toggle edge; cnt continues; no partial half-period on the output.
- Undefined: on DIVIDE completion from RUN, half loads immediately, cnt←0, tone_out retains its level; one shortened/lengthened half-period allowed.
- Entry from SILENT behaves identically in both builds.

## Test plan
- Reset: rst high 3 cycles → ready=1, tone_out=0, active=0; hold for 10 cycles, no toggles.
- Bench CLK_HZ=1000, DIV_W=16: load freq=50 valid → ready low exactly 16 cycles, then tone_out toggles every 10 cycles (period 20), active=1.
- Clamp: load freq=1000 → half=1000/2000=0 → clamped 1, tone_out toggles every cycle; CNT_W=4, freq=1 → half=500 saturates to 15.
- Retune in RUN: freq=50 running, load freq=131 (half=3) → old 10-cycle toggles continue through DIVIDE; GLITCHFREE build: switch at next toggle edge; other build: cnt resets on completion edge.
- Rest/ignored: load freq_valid=0 → tone_out=0, active=0 next cycle; load asserted during DIVIDE → no effect, first result delivered.
- Reset mid-DIVIDE at cycle 8 → all outputs reset values, ready=1 next cycle, no tone starts.
